// File: rtl/led_pkg.sv
// Shared types and helpers for the LED blink engine: half-period type,
// per-channel mode encoding and the mode decoder.
package led_pkg;

   localparam int LED_PERIOD_W = 16;

   typedef logic [LED_PERIOD_W-1:0] period_t;

   typedef enum logic [1:0] {
      CH_OFF   = 2'd0,
      CH_SOLID = 2'd1,
      CH_BLINK = 2'd2
   } ch_mode_e;

   // Zero means dark, all-ones means steady on, anything else blinks.
   function automatic ch_mode_e decode_mode(input period_t period);
      ch_mode_e mode;
      if (period == period_t'(0)) begin
         mode = CH_OFF;
      end else if (&period) begin
         mode = CH_SOLID;
      end else begin
         mode = CH_BLINK;
      end
      return mode;
   endfunction

endpackage

// File: rtl/led_blink_chan.sv
// One LED channel: captures its half-period, restarts on any change and
// toggles the LED every period_q ticks while in blink mode.
module led_blink_chan
   import led_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    tick,
   input  period_t period,
   output logic    led
);

   localparam period_t CNT_ONE = period_t'(1);

   period_t  period_q_r;
   period_t  cnt_r;
   logic     led_r;

   period_t  cnt_nxt_s;
   logic     led_nxt_s;
   logic     restart_s;
   ch_mode_e mode_s;

   assign restart_s = (period != period_q_r);
   assign mode_s    = decode_mode(period_q_r);

   // Next counter/LED value: a restart wins over the mode behaviour and any tick.
   always_comb begin
      cnt_nxt_s = cnt_r;
      led_nxt_s = led_r;
      if (restart_s) begin
         cnt_nxt_s = period_t'(0);
         led_nxt_s = (period != period_t'(0));
      end else begin
         case (mode_s)
            CH_OFF: begin
               cnt_nxt_s = period_t'(0);
               led_nxt_s = 1'b0;
            end
            CH_SOLID: begin
               cnt_nxt_s = period_t'(0);
               led_nxt_s = 1'b1;
            end
            CH_BLINK: begin
               if (tick) begin
                  // The >= compare keeps cnt bounded even if it ever exceeds the period.
                  if (cnt_r >= (period_q_r - CNT_ONE)) begin
                     cnt_nxt_s = period_t'(0);
                     led_nxt_s = ~led_r;
                  end else begin
                     cnt_nxt_s = cnt_r + CNT_ONE;
                     led_nxt_s = led_r;
                  end
               end else begin
                  cnt_nxt_s = cnt_r;
                  led_nxt_s = led_r;
               end
            end
            default: begin
               cnt_nxt_s = period_t'(0);
               led_nxt_s = 1'b0;
            end
         endcase
      end
   end

   // Channel state registers; reset has priority over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         period_q_r <= period_t'(0);
         cnt_r      <= period_t'(0);
         led_r      <= 1'b0;
      end else begin
         period_q_r <= period;
         cnt_r      <= cnt_nxt_s;
         led_r      <= led_nxt_s;
      end
   end

   assign led = led_r;

endmodule

// File: rtl/led_blink_engine.sv
// Multi-channel LED blink generator: a shared prescaler derives the tick
// time base and each channel produces an independent square wave from it.
module led_blink_engine
   import led_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int PERIOD_W    = LED_PERIOD_W,
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int TICK_HZ     = 1000
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_CH*PERIOD_W-1:0] period_i,
   output logic [N_CH-1:0]          led_o,
   output logic                     tick_o
);

   localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(DIV - 1);
   localparam logic [PRE_W-1:0] PRE_BEFORE = PRE_W'((DIV > 1) ? (DIV - 2) : 0);
   localparam logic [PRE_W-1:0] PRE_ONE    = PRE_W'(1);

   if (DIV < 2) begin : g_div_check
      $error("led_blink_engine: CLK_FREQ_HZ/TICK_HZ must be at least 2");
   end

   if (PERIOD_W != LED_PERIOD_W) begin : g_width_check
      $error("led_blink_engine: PERIOD_W must match led_pkg::LED_PERIOD_W");
   end

   logic [PRE_W-1:0] pre_cnt_r;
   logic             tick_r;

   // Prescaler: count 0..DIV-1; tick register is set one cycle early so it is high exactly at DIV-1.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt_r <= '0;
         tick_r    <= 1'b0;
      end else begin
         if (pre_cnt_r == PRE_LAST) begin
            pre_cnt_r <= '0;
         end else begin
            pre_cnt_r <= pre_cnt_r + PRE_ONE;
         end
         tick_r <= (pre_cnt_r == PRE_BEFORE);
      end
   end

   assign tick_o = tick_r;

   for (genvar k = 0; k < N_CH; k++) begin : g_chan
      led_blink_chan u_chan (
         .clk    (clk),
         .reset  (reset),
         .tick   (tick_r),
         .period (period_i[k*PERIOD_W +: PERIOD_W]),
         .led    (led_o[k])
      );
   end

endmodule

// File: tb/tb_led_blink_engine.sv
// Bench for led_blink_engine with a 10-cycle tick (DIV=10): a directed
// vector table, hand-written corner sequences and a randomized run, all
// checked every cycle against a tick-counting reference model.
module tb_led_blink_engine;

   localparam int N_CH = 4;
   localparam int PW   = 16;
   localparam int DIV  = 10;

   logic                 clk;
   logic                 reset;
   logic [N_CH*PW-1:0]   period_i;
   logic [N_CH-1:0]      led_o;
   logic                 tick_o;

   int n_cmp;
   int n_bad;

   // Reference model: cycles since reset release, last seen period, ticks since restart.
   int          m_cyc;
   logic [15:0] m_pq  [N_CH];
   logic        m_led [N_CH];
   int          m_nt  [N_CH];

   typedef struct {
      logic        rst;
      logic [63:0] per;
      int          n;
      logic [3:0]  exp_led;
      logic        exp_tick;
   } vec_t;

   vec_t tbl[$];

   led_blink_engine #(
      .N_CH        (N_CH),
      .PERIOD_W    (PW),
      .CLK_FREQ_HZ (1000),
      .TICK_HZ     (100)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .period_i (period_i),
      .led_o    (led_o),
      .tick_o   (tick_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [3:0] model_leds();
      logic [3:0] v;
      for (int k = 0; k < N_CH; k++) v[k] = m_led[k];
      return v;
   endfunction

   function automatic logic model_tick();
      return (m_cyc % DIV) == (DIV - 1);
   endfunction

   // Advance the model across one clock edge with the given inputs.
   task automatic model_edge(input logic r, input logic [63:0] p);
      logic        tk;
      logic [15:0] pk;
      tk = model_tick();
      if (r) begin
         m_cyc = 0;
         for (int k = 0; k < N_CH; k++) begin
            m_pq[k] = 16'd0; m_led[k] = 1'b0; m_nt[k] = 0;
         end
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            pk = p[k*PW +: PW];
            if (pk != m_pq[k]) begin
               m_nt[k]  = 0;
               m_led[k] = (pk != 16'd0);
            end else if (m_pq[k] == 16'd0) begin
               m_led[k] = 1'b0;
            end else if (m_pq[k] == 16'hFFFF) begin
               m_led[k] = 1'b1;
            end else begin
               if (tk) m_nt[k] = m_nt[k] + 1;
               // LED is high during even-numbered half-periods since restart.
               m_led[k] = ((m_nt[k] / int'(m_pq[k])) % 2) == 0;
            end
            m_pq[k] = pk;
         end
         m_cyc = m_cyc + 1;
      end
   endtask

   // One clock cycle: drive inputs, update model, sample on the falling edge.
   task automatic step(input logic r, input logic [63:0] p);
      reset    = r;
      period_i = p;
      model_edge(r, p);
      @(posedge clk);
      @(negedge clk);
      chk("model_led", {28'd0, led_o}, {28'd0, model_leds()});
      chk("model_tick", {31'd0, tick_o}, {31'd0, model_tick()});
   endtask

   task automatic run(input logic r, input logic [63:0] p, input int n);
      for (int i = 0; i < n; i++) step(r, p);
   endtask

   initial begin
      logic [63:0] per;
      logic [63:0] p_ch0_3, p_ch1_ff, p_all1, p_ch3_5, p_ch3_2;
      logic [15:0] v;
      int          ch;
      int          sel;
      n_cmp    = 0;
      n_bad    = 0;
      m_cyc    = 0;
      reset    = 1'b1;
      period_i = '0;
      for (int k = 0; k < N_CH; k++) begin
         m_pq[k] = 16'd0; m_led[k] = 1'b0; m_nt[k] = 0;
      end

      p_ch0_3  = 64'h0000_0000_0000_0003;
      p_ch1_ff = 64'h0000_0000_FFFF_0000;
      p_all1   = 64'h0001_0001_0001_0001;
      p_ch3_5  = 64'h0005_0000_0000_0000;
      p_ch3_2  = 64'h0002_0000_0000_0000;

      // Idle after reset: LEDs dark, tick every 10 cycles.
      tbl.push_back('{1'b1, 64'd0, 5, 4'b0000, 1'b0});
      tbl.push_back('{1'b0, 64'd0, 8, 4'b0000, 1'b0});
      tbl.push_back('{1'b0, 64'd0, 1, 4'b0000, 1'b1});
      tbl.push_back('{1'b0, 64'd0, 1, 4'b0000, 1'b0});
      tbl.push_back('{1'b0, 64'd0, 9, 4'b0000, 1'b1});
      // ch0 period 3: on one cycle after release, toggles every 3rd tick.
      tbl.push_back('{1'b1, p_ch0_3, 1, 4'b0000, 1'b0});
      tbl.push_back('{1'b0, p_ch0_3, 1, 4'b0001, 1'b0});
      tbl.push_back('{1'b0, p_ch0_3, 28, 4'b0001, 1'b1});
      tbl.push_back('{1'b0, p_ch0_3, 1, 4'b0000, 1'b0});
      tbl.push_back('{1'b0, p_ch0_3, 29, 4'b0000, 1'b1});
      tbl.push_back('{1'b0, p_ch0_3, 1, 4'b0001, 1'b0});
      // ch1 solid, ch2 off over 500 cycles.
      tbl.push_back('{1'b1, p_ch1_ff, 1, 4'b0000, 1'b0});
      tbl.push_back('{1'b0, p_ch1_ff, 1, 4'b0010, 1'b0});
      tbl.push_back('{1'b0, p_ch1_ff, 500, 4'b0010, 1'b0});
      // All channels period 1: toggle together on every tick.
      tbl.push_back('{1'b1, p_all1, 1, 4'b0000, 1'b0});
      tbl.push_back('{1'b0, p_all1, 1, 4'b1111, 1'b0});
      tbl.push_back('{1'b0, p_all1, 8, 4'b1111, 1'b1});
      tbl.push_back('{1'b0, p_all1, 1, 4'b0000, 1'b0});
      tbl.push_back('{1'b0, p_all1, 10, 4'b1111, 1'b0});

      for (int i = 0; i < tbl.size(); i++) begin
         run(tbl[i].rst, tbl[i].per, tbl[i].n);
         chk("tbl_led", {28'd0, led_o}, {28'd0, tbl[i].exp_led});
         chk("tbl_tick", {31'd0, tick_o}, {31'd0, tbl[i].exp_tick});
      end

      // Period change coinciding with a tick while the LED is low: restart wins.
      run(1'b1, p_ch3_5, 1);
      run(1'b0, p_ch3_5, 59);
      chk("chg_pre_led3", {31'd0, led_o[3]}, 32'd0);
      chk("chg_pre_tick", {31'd0, tick_o}, 32'd1);
      run(1'b0, p_ch3_2, 1);
      chk("chg_restart_led3", {31'd0, led_o[3]}, 32'd1);
      run(1'b0, p_ch3_2, 19);
      chk("chg_hold_led3", {31'd0, led_o[3]}, 32'd1);
      run(1'b0, p_ch3_2, 1);
      chk("chg_toggle_led3", {31'd0, led_o[3]}, 32'd0);

      // One-cycle reset mid-blink with the LED on.
      run(1'b1, p_ch0_3, 1);
      run(1'b0, p_ch0_3, 5);
      chk("rst_pre_led", {28'd0, led_o}, 32'd1);
      run(1'b1, p_ch0_3, 1);
      chk("rst_led", {28'd0, led_o}, 32'd0);
      chk("rst_tick", {31'd0, tick_o}, 32'd0);
      run(1'b0, p_ch0_3, 1);
      chk("rst_restart_led", {28'd0, led_o}, 32'd1);
      run(1'b0, p_ch0_3, 7);
      chk("rst_phase_notick", {31'd0, tick_o}, 32'd0);
      run(1'b0, p_ch0_3, 1);
      chk("rst_phase_tick", {31'd0, tick_o}, 32'd1);

      // Randomized periods, changes and occasional resets against the model.
      per = '0;
      run(1'b1, per, 1);
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            ch  = $urandom_range(0, N_CH - 1);
            sel = $urandom_range(0, 7);
            case (sel)
               0:       v = 16'h0000;
               1:       v = 16'hFFFF;
               2:       v = 16'hFFFE;
               default: v = 16'($urandom_range(1, 5));
            endcase
            per[ch*PW +: PW] = v;
         end
         step($urandom_range(0, 299) == 0, per);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
